// File: rtl/pat_pkg.sv
// Shared defaults and record type for the pattern-match logger.
package pat_pkg;
  localparam int PAT_DEPTH = 4;
  localparam int PAT_IDX_W = 8;
  localparam int PAT_CNT_W = 8;

  typedef logic [PAT_IDX_W-1:0] rec_t;
endpackage

// File: rtl/pat_fifo.sv
// Synchronous show-ahead FIFO; rd_data is the head entry read combinationally from storage.
// Pushes are refused when full unless a pop happens in the same cycle; pops are ignored while empty.
module pat_fifo
  import pat_pkg::*;
#(
  parameter int DEPTH = PAT_DEPTH,
  parameter int W     = PAT_IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_pop, do_wr;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_pop = rd_en && !empty;
  assign do_wr  = wr_en && (!full || do_pop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_wr && !reset) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/pat_match_logger.sv
// Logs the bit position of each upstream match flag into a small FIFO and counts events.
// Optional saturating drop counter enabled by PAT_DROP_CNT_EN.
module pat_match_logger
  import pat_pkg::*;
#(
  parameter int DEPTH = PAT_DEPTH,
  parameter int IDX_W = PAT_IDX_W,
  parameter int CNT_W = PAT_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flag,
  input  logic                     rd_en,
  output logic [IDX_W-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         match_cnt
`ifdef PAT_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]         drop_cnt
`endif
);
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             wr_en;

  // A full buffer still takes the new record when the head leaves in the same cycle.
  assign wr_en = flag && (!full || (rd_en && !empty));

  pat_fifo #(.DEPTH(DEPTH), .W(IDX_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (bit_idx_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

  assign bit_idx_d   = bit_idx_q + IDX_W'(1);
  assign match_cnt_d = (flag && match_cnt_q != '1) ? match_cnt_q + CNT_W'(1) : match_cnt_q;
  assign match_cnt   = match_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      bit_idx_q   <= bit_idx_d;
      match_cnt_q <= match_cnt_d;
    end
  end

`ifdef PAT_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt_d = (flag && !wr_en && drop_cnt_q != '1) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
  assign drop_cnt   = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end
`endif
endmodule

// File: tb/tb_pat_match_logger.sv
// Bench for pat_match_logger: directed scenarios plus random traffic against a queue-based model.
module tb_pat_match_logger;
  localparam int DEPTH = 4;
  localparam int IDX_W = 8;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flag = 1'b0;
  logic             rd_en = 1'b0;
  logic [IDX_W-1:0] rd_data;
  logic             empty, full;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] match_cnt;
`ifdef PAT_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_q[$];
  int m_idx = 0;
  int m_match = 0;
  int m_drop = 0;

  always #5 clk = ~clk;

  pat_match_logger #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flag      (flag),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .match_cnt (match_cnt)
`ifdef PAT_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // Drive one cycle of inputs, advance the model across the edge, return at the next negedge.
  task automatic cycle(input logic f, input logic r, input logic rs);
    bit pop, wr;
    flag  = f;
    rd_en = r;
    reset = rs;
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_idx = 0; m_match = 0; m_drop = 0;
    end else begin
      pop = r && (m_q.size() > 0);
      wr  = f && ((m_q.size() < DEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (wr) m_q.push_back(m_idx);
      if (f && m_match < 255) m_match++;
      if (f && !wr && m_drop < 255) m_drop++;
      m_idx = (m_idx + 1) % 256;
    end
    @(negedge clk);
    flag = 1'b0; rd_en = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    cycle(0, 0, 1);
    cycle(0, 1, 1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
    checks++; if (level !== 0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (match_cnt !== 0) begin errors++; $display("FAIL reset_match got %0d want 0", match_cnt); end
`ifdef PAT_DROP_CNT_EN
    checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
`endif
  endtask

  task automatic test_three_events();
    int exp[3] = '{5, 12, 20};
    cycle(0, 0, 1);
    for (int i = 0; i < 25; i++) cycle(i == 5 || i == 12 || i == 20, 0, 0);
    checks++; if (level !== 3) begin errors++; $display("FAIL three_level got %0d want 3", level); end
    checks++; if (match_cnt !== 3) begin errors++; $display("FAIL three_match got %0d want 3", match_cnt); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_data !== IDX_W'(exp[i])) begin errors++; $display("FAIL three_pop%0d got %0d want %0d", i, rd_data, exp[i]); end
      cycle(0, 1, 0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL three_drained got %0b want 1", empty); end
  endtask

  task automatic test_overflow();
    cycle(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 0);
      if (i == 3) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %0b want 1", full); end
      end
    end
    checks++; if (level !== 4) begin errors++; $display("FAIL ovf_level got %0d want 4", level); end
    checks++; if (match_cnt !== 6) begin errors++; $display("FAIL ovf_match got %0d want 6", match_cnt); end
`ifdef PAT_DROP_CNT_EN
    checks++; if (drop_cnt !== 2) begin errors++; $display("FAIL ovf_drop got %0d want 2", drop_cnt); end
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data !== IDX_W'(i)) begin errors++; $display("FAIL ovf_pop%0d got %0d want %0d", i, rd_data, i); end
      cycle(0, 1, 0);
    end
  endtask

  task automatic test_full_wr_pop();
    int d0;
    cycle(0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);
    d0 = m_drop;
    cycle(1, 1, 0); // bit_idx 4 replaces the oldest record (0)
    checks++; if (level !== 4) begin errors++; $display("FAIL fullrw_level got %0d want 4", level); end
    checks++; if (rd_data !== 8'd1) begin errors++; $display("FAIL fullrw_head got %0d want 1", rd_data); end
    checks++; if (m_drop !== d0) begin errors++; $display("FAIL fullrw_model_drop got %0d want %0d", m_drop, d0); end
`ifdef PAT_DROP_CNT_EN
    checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL fullrw_drop got %0d want 0", drop_cnt); end
`endif
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rd_data !== IDX_W'(i)) begin errors++; $display("FAIL fullrw_pop%0d got %0d want %0d", i, rd_data, i); end
      cycle(0, 1, 0);
    end
  endtask

  task automatic test_empty_wr_pop();
    int idx;
    cycle(0, 0, 1);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0);
    idx = m_idx;
    cycle(1, 1, 0);
    checks++; if (level !== 1) begin errors++; $display("FAIL emptyrw_level got %0d want 1", level); end
    checks++; if (rd_data !== IDX_W'(idx)) begin errors++; $display("FAIL emptyrw_data got %0d want %0d", rd_data, idx); end
  endtask

  task automatic test_wrap();
    cycle(0, 0, 1);
    for (int i = 0; i < 300; i++) cycle(i == 258, 0, 0);
    checks++; if (level !== 1) begin errors++; $display("FAIL wrap_level got %0d want 1", level); end
    checks++; if (rd_data !== 8'd2) begin errors++; $display("FAIL wrap_data got %0d want 2", rd_data); end
  endtask

  task automatic test_saturate();
    cycle(0, 0, 1);
    for (int i = 0; i < 260; i++) cycle(1, 1, 0);
    checks++; if (match_cnt !== 8'd255) begin errors++; $display("FAIL sat_match got %0d want 255", match_cnt); end
`ifdef PAT_DROP_CNT_EN
    checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL sat_drop got %0d want 0", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    cycle(1, 1, 1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %0b want 1", empty); end
    checks++; if (level !== 0) begin errors++; $display("FAIL rstmid_level got %0d want 0", level); end
    checks++; if (match_cnt !== 0) begin errors++; $display("FAIL rstmid_match got %0d want 0", match_cnt); end
    cycle(1, 0, 0);
    checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL rstmid_idx got %0d want 0", rd_data); end
  endtask

  task automatic test_random();
    cycle(0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 40, $urandom_range(0, 199) == 0);
      checks++;
      if (level !== LW'(m_q.size()) || empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH)) begin
        errors++;
        $display("FAIL rnd_state cyc %0d got level %0d empty %0b full %0b want level %0d", i, level, empty, full, m_q.size());
      end
      checks++;
      if (match_cnt !== CNT_W'(m_match)) begin errors++; $display("FAIL rnd_match cyc %0d got %0d want %0d", i, match_cnt, m_match); end
      if (m_q.size() > 0) begin
        checks++;
        if (rd_data !== IDX_W'(m_q[0])) begin errors++; $display("FAIL rnd_head cyc %0d got %0d want %0d", i, rd_data, m_q[0]); end
      end
`ifdef PAT_DROP_CNT_EN
      checks++;
      if (drop_cnt !== CNT_W'(m_drop)) begin errors++; $display("FAIL rnd_drop cyc %0d got %0d want %0d", i, drop_cnt, m_drop); end
`endif
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_three_events();
    test_overflow();
    test_full_wr_pop();
    test_empty_wr_pop();
    test_wrap();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
